// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// N-channel round-robin arbiter between several memory masters and one shared
// SRAM-style slave port (sel/we/byte_en/addr/din/dout/ack). A granted request
// is registered onto the slave port and held there until the slave acks. The
// ack and read data are then routed back to the granted channel.
//
// Optional feature (compile-time macro MEM_ARB_TIMEOUT_EN):
//   When defined, a BUSY-cycle counter ends a transfer that has not been acked
//   after TIMEOUT cycles. It completes with m_ack and m_err set and read data 0.
//   When undefined, BUSY waits indefinitely, m_err is tied to 0 and TIMEOUT
//   is ignored.
//
// Parameters:
//   NCH      number of master channels (>= 1)
//   AW       address width
//   DW       data width (multiple of 8), byte-mask width MW = DW/8
//   TIMEOUT  BUSY-cycle limit before an error response (>= 1)
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   m_sel   [NCH]     per-channel request, held with payload until its ack
//   m_we    [NCH]     per-channel write enable
//   m_addr  [NCH*AW]  channel i at [i*AW +: AW]
//   m_wdata [NCH*DW]  channel i at [i*DW +: DW]
//   m_wmask [NCH*MW]  byte-lane write mask, channel i at [i*MW +: MW]
//   m_rdata [DW]      shared read data, 0 unless an m_ack bit is high
//   m_ack   [NCH]     one-hot completion pulse
//   m_err   [NCH]     error flag, qualified by m_ack
//   s_sel, s_we       registered slave request / write enable
//   s_addr, s_wdata,
//   s_wmask           registered slave payload
//   s_rdata, s_ack    slave read data and completion (ack may come with s_sel)
//   busy              high while a transfer is outstanding
// -----------------------------------------------------------------------------

module mem_arbiter #(
   parameter int unsigned NCH     = 2,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        m_sel,
   input  logic [NCH-1:0]        m_we,
   input  logic [NCH*AW-1:0]     m_addr,
   input  logic [NCH*DW-1:0]     m_wdata,
   input  logic [NCH*(DW/8)-1:0] m_wmask,
   output logic [DW-1:0]         m_rdata,
   output logic [NCH-1:0]        m_ack,
   output logic [NCH-1:0]        m_err,
   output logic                  s_sel,
   output logic                  s_we,
   output logic [AW-1:0]         s_addr,
   output logic [DW-1:0]         s_wdata,
   output logic [DW/8-1:0]       s_wmask,
   input  logic [DW-1:0]         s_rdata,
   input  logic                  s_ack,
   output logic                  busy
);

   localparam int unsigned MW = DW / 8;
   localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

   // Elaboration-time parameter sanity checks.
   if (NCH < 1) begin : g_chk_nch
      $error("mem_arbiter: NCH must be at least 1");
   end
   if ((DW == 0) || (DW % 8 != 0)) begin : g_chk_dw
      $error("mem_arbiter: DW must be a non-zero multiple of 8");
   end
   if (TIMEOUT < 1) begin : g_chk_timeout
      $error("mem_arbiter: TIMEOUT must be at least 1");
   end

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   grant_q, grant_d;
   logic            s_sel_q, s_sel_d;
   logic            s_we_q, s_we_d;
   logic [AW-1:0]   s_addr_q, s_addr_d;
   logic [DW-1:0]   s_wdata_q, s_wdata_d;
   logic [MW-1:0]   s_wmask_q, s_wmask_d;

   logic            req_any;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   cand;
   logic            tmo;
   logic            done;

   // (base + off) mod NCH, for off < NCH.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                               input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= NCH) begin
         sum = sum - NCH;
      end
      return PW'(sum);
   endfunction

   // ---------------------------------------------------------------------------
   // Round-robin pick: first requester scanning ptr, ptr+1, ... with wrap.
   // ---------------------------------------------------------------------------
   always_comb begin
      req_any = 1'b0;
      pick    = ptr_q;
      cand    = ptr_q;
      for (int unsigned k = 0; k < NCH; k++) begin
         cand = wrap_add(ptr_q, k);
         if (!req_any && m_sel[cand]) begin
            req_any = 1'b1;
            pick    = cand;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Optional bus timeout
   // ---------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // An s_ack in the timeout cycle wins, so tmo requires !s_ack.
   assign tmo = (state_q == StBusy) && !s_ack && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (!s_ack) begin
         cnt_d = cnt_q + 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   assign done = (state_q == StBusy) && (s_ack || tmo);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      s_sel_d   = s_sel_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_wmask_d = s_wmask_q;

      case (state_q)
         StIdle: begin
            // Payload holds its last value while idle with no request.
            if (req_any) begin
               grant_d   = pick;
               s_sel_d   = 1'b1;
               s_we_d    = m_we[pick];
               s_addr_d  = m_addr[pick*AW +: AW];
               s_wdata_d = m_wdata[pick*DW +: DW];
               s_wmask_d = m_wmask[pick*MW +: MW];
               state_d   = StBusy;
            end
         end
         StBusy: begin
            if (done) begin
               s_sel_d = 1'b0;
               ptr_d   = wrap_add(grant_q, 1);
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and registered slave-port outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         grant_q   <= '0;
         s_sel_q   <= 1'b0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_wmask_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         s_sel_q   <= s_sel_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_wmask_q <= s_wmask_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Completion routing back to the granted master
   // ---------------------------------------------------------------------------
   always_comb begin
      m_ack   = '0;
      m_err   = '0;
      m_rdata = '0;
      // Reset aborts the transfer: suppress any ack arriving in the reset cycle.
      if (done && !rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_q == PW'(i)) begin
               m_ack[i] = 1'b1;
               m_err[i] = tmo;
            end
         end
         if (s_ack) begin
            m_rdata = s_rdata;
         end
      end
   end

   assign s_sel   = s_sel_q;
   assign s_we    = s_we_q;
   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign s_wmask = s_wmask_q;
   assign busy    = (state_q == StBusy);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter (NCH=4, AW=DW=32, TIMEOUT=8) with a behavioural
// SRAM slave model and a queue of expected completions.
`timescale 1ns/1ps

module tb_mem_arbiter;

   localparam int unsigned NCH = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned MW  = DW / 8;
   localparam int unsigned TMO = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      m_sel;
   logic [NCH-1:0]      m_we;
   logic [NCH*AW-1:0]   m_addr;
   logic [NCH*DW-1:0]   m_wdata;
   logic [NCH*MW-1:0]   m_wmask;
   logic [DW-1:0]       m_rdata;
   logic [NCH-1:0]      m_ack;
   logic [NCH-1:0]      m_err;
   logic                s_sel;
   logic                s_we;
   logic [AW-1:0]       s_addr;
   logic [DW-1:0]       s_wdata;
   logic [MW-1:0]       s_wmask;
   logic [DW-1:0]       s_rdata;
   logic                s_ack;
   logic                busy;

   always #5 clk = ~clk;

   mem_arbiter #(
      .NCH     (NCH),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m_sel   (m_sel),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_wmask (m_wmask),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .s_sel   (s_sel),
      .s_we    (s_we),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_wmask (s_wmask),
      .s_rdata (s_rdata),
      .s_ack   (s_ack),
      .busy    (busy)
   );

   // ---------------------------------------------------------------------------
   // Slave model: word memory, unwritten words return a fixed pattern.
   // ---------------------------------------------------------------------------
   int unsigned s_waits = 0;
   bit          s_hang  = 1'b0;
   bit          s_force = 1'b0;
   int unsigned wcnt    = 0;
   logic [31:0] mem [0:1023];
   bit          mem_valid [0:1023];
   logic [9:0]  sidx;
   logic [31:0] wmerge;

   function automatic logic [31:0] pat(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      if (a < 32'h100) return 32'h0;
      return {16'hC0DE, a[15:0]};
   endfunction

   assign sidx  = s_addr[11:2];
   assign s_ack = s_sel && (s_force || (!s_hang && (wcnt >= s_waits)));

   always_comb begin
      s_rdata = '0;
      if (s_sel && !s_we) s_rdata = mem_valid[sidx] ? mem[sidx] : pat(s_addr);
   end

   always_comb begin
      wmerge = mem_valid[sidx] ? mem[sidx] : pat(s_addr);
      for (int b = 0; b < int'(MW); b++) begin
         if (s_wmask[b]) wmerge[8*b +: 8] = s_wdata[8*b +: 8];
      end
   end

   always @(posedge clk) begin
      if (s_sel && !s_ack) wcnt <= wcnt + 1;
      else                 wcnt <= 0;
      if (s_sel && s_ack && s_we) begin
         mem[sidx]       <= wmerge;
         mem_valid[sidx] <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard and counters
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [NCH-1:0] ack;
      logic [DW-1:0]  rdata;
      logic [NCH-1:0] err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic push_exp(input int c, input logic [31:0] rd, input logic err);
      exp_t e;
      e.ack      = '0;
      e.ack[c]   = 1'b1;
      e.rdata    = rd;
      e.err      = '0;
      e.err[c]   = err;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int c, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] mask);
      m_we[c]              = we;
      m_addr[c*AW +: AW]   = addr;
      m_wdata[c*DW +: DW]  = wd;
      m_wmask[c*MW +: MW]  = mask;
      m_sel[c]             = 1'b1;
   endtask

   // Waits (bounded) for the next ack; ack stays 0 when the budget expires.
   task automatic wait_ack(input int budget, output exp_t got, output int cyc);
      bit seen;
      seen = 1'b0;
      got  = '0;
      cyc  = 0;
      while (cyc < budget && !seen) begin
         @(negedge clk);
         cyc++;
         if (m_ack != '0) begin
            got.ack   = m_ack;
            got.rdata = m_rdata;
            got.err   = m_err;
            seen      = 1'b1;
         end
      end
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_edge();
      rst   = 1'b1;
      m_sel = '0;
      next_edge();
      rst   = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      m_sel   = '1;
      m_we    = '1;
      m_addr  = '1;
      m_wdata = '1;
      m_wmask = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({s_sel, s_we, busy} !== 3'b000) begin
         bad++;
         $display("FAIL reset_ctrl: sel/we/busy=%b want 000", {s_sel, s_we, busy});
      end
      total++;
      if ({s_addr, s_wdata, s_wmask} !== '0) begin
         bad++;
         $display("FAIL reset_payload: addr=%h wdata=%h wmask=%b want 0", s_addr, s_wdata,
                  s_wmask);
      end
      total++;
      if ({m_ack, m_err, m_rdata} !== '0) begin
         bad++;
         $display("FAIL reset_master: ack=%b err=%b rdata=%h want 0", m_ack, m_err, m_rdata);
      end
      next_edge();
      m_sel   = '0;
      m_we    = '0;
      m_addr  = '0;
      m_wdata = '0;
      m_wmask = '0;
      rst     = 1'b0;
   endtask

   task automatic test_single_read();
      exp_t got, e;
      int   cyc;
      s_waits = 0;
      set_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
      push_exp(0, 32'hDEADBEEF, 1'b0);
      wait_ack(10, got, cyc);
      total++;
      if (cyc !== 2) begin
         bad++;
         $display("FAIL read_latency: cycles=%0d want 2", cyc);
      end
      total++;
      if ({s_sel, s_we, s_addr} !== {1'b1, 1'b0, 32'h100}) begin
         bad++;
         $display("FAIL read_slave: sel=%b we=%b addr=%h want 1 0 00000100", s_sel, s_we, s_addr);
      end
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL read_sb: ack=%b rdata=%h err=%b want ack=%b rdata=%h err=%b",
                  got.ack, got.rdata, got.err, e.ack, e.rdata, e.err);
      end
      next_edge();
      m_sel[0] = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, m_ack, m_rdata} !== '0) begin
         bad++;
         $display("FAIL read_idle: busy=%b ack=%b rdata=%h want 0", busy, m_ack, m_rdata);
      end
   endtask

   task automatic test_simultaneous();
      exp_t got, e;
      int   cyc;
      int   order [4] = '{0, 1, 3, 0};
      do_reset();
      s_waits = 0;
      set_req(0, 1'b0, 32'h300, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h304, 32'h0, 4'hF);
      push_exp(0, 32'hC0DE0300, 1'b0);
      push_exp(1, 32'hC0DE0304, 1'b0);
      push_exp(3, 32'hC0DE030C, 1'b0);
      push_exp(0, 32'hC0DE0308, 1'b0);
      for (int i = 0; i < 4; i++) begin
         wait_ack(10, got, cyc);
         e = exp_q.pop_front();
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL simul_sb[%0d]: ack=%b rdata=%h err=%b want ack=%b rdata=%h err=%b",
                     i, got.ack, got.rdata, got.err, e.ack, e.rdata, e.err);
         end
         total++;
         if (cyc !== 2) begin
            bad++;
            $display("FAIL simul_gap[%0d]: cycles=%0d want 2", i, cyc);
         end
         next_edge();
         m_sel[order[i]] = 1'b0;
         // After ch0 and ch1, ptr is 2: ch3 must beat ch0 across the wrap.
         if (i == 1) begin
            set_req(0, 1'b0, 32'h308, 32'h0, 4'hF);
            set_req(3, 1'b0, 32'h30C, 32'h0, 4'hF);
         end
      end
   endtask

   task automatic test_masked_write();
      exp_t got, e;
      int   cyc;
      s_waits = 3;
      set_req(1, 1'b1, 32'h40, 32'h12345678, 4'b0011);
      push_exp(1, 32'h0, 1'b0);
      wait_ack(20, got, cyc);
      total++;
      if (cyc !== 5) begin
         bad++;
         $display("FAIL wr_latency: cycles=%0d want 5", cyc);
      end
      total++;
      if ({s_we, s_wmask, s_wdata, s_addr} !== {1'b1, 4'b0011, 32'h12345678, 32'h40}) begin
         bad++;
         $display("FAIL wr_slave: we=%b wmask=%b wdata=%h addr=%h want 1 0011 12345678 00000040",
                  s_we, s_wmask, s_wdata, s_addr);
      end
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL wr_sb: ack=%b rdata=%h err=%b want ack=%b rdata=%h err=%b",
                  got.ack, got.rdata, got.err, e.ack, e.rdata, e.err);
      end
      next_edge();
      set_req(1, 1'b0, 32'h40, 32'h0, 4'b1010);
      push_exp(1, 32'h00005678, 1'b0);
      wait_ack(20, got, cyc);
      total++;
      if ({s_we, s_wmask} !== {1'b0, 4'b1010}) begin
         bad++;
         $display("FAIL rd_mask_pass: we=%b wmask=%b want 0 1010", s_we, s_wmask);
      end
      e = exp_q.pop_front();
      total++;
      if (got !== e || cyc !== 5) begin
         bad++;
         $display("FAIL rd_back_sb: ack=%b rdata=%h err=%b cyc=%0d want ack=%b rdata=%h err=%b cyc=5",
                  got.ack, got.rdata, got.err, cyc, e.ack, e.rdata, e.err);
      end
      next_edge();
      m_sel[1] = 1'b0;
   endtask

   task automatic test_reset_mid();
      exp_t got, e;
      int   cyc;
      s_waits = 0;
      s_hang  = 1'b1;
      set_req(2, 1'b0, 32'h600, 32'h0, 4'hF);
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_busy: busy=%b want 1", busy);
      end
      next_edge();
      rst     = 1'b1;
      s_force = 1'b1;
      @(negedge clk);
      total++;
      if (m_ack !== '0) begin
         bad++;
         $display("FAIL rstmid_noack: ack=%b want 0000", m_ack);
      end
      next_edge();
      rst      = 1'b0;
      s_force  = 1'b0;
      s_hang   = 1'b0;
      m_sel[2] = 1'b0;
      @(negedge clk);
      total++;
      if ({s_sel, busy, m_ack} !== '0) begin
         bad++;
         $display("FAIL rstmid_after: sel=%b busy=%b ack=%b want 0 0 0000", s_sel, busy, m_ack);
      end
      // ptr must be back at 0: ch0 wins over ch3.
      next_edge();
      set_req(0, 1'b0, 32'h604, 32'h0, 4'hF);
      set_req(3, 1'b0, 32'h608, 32'h0, 4'hF);
      push_exp(0, 32'hC0DE0604, 1'b0);
      push_exp(3, 32'hC0DE0608, 1'b0);
      for (int i = 0; i < 2; i++) begin
         wait_ack(10, got, cyc);
         e = exp_q.pop_front();
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL rstmid_ptr[%0d]: ack=%b rdata=%h want ack=%b rdata=%h",
                     i, got.ack, got.rdata, e.ack, e.rdata);
         end
         next_edge();
         m_sel[(i == 0) ? 0 : 3] = 1'b0;
      end
   endtask

   task automatic test_fairness();
      exp_t got, e;
      int   cyc;
      int   cnt [NCH];
      do_reset();
      s_waits = 0;
      for (int c = 0; c < int'(NCH); c++) begin
         cnt[c] = 0;
         set_req(c, 1'b0, 32'h200 + 32'(4 * c), 32'h0, 4'hF);
      end
      for (int i = 0; i < 16; i++) begin
         push_exp(i % 4, 32'hC0DE0200 + 32'(4 * (i % 4)), 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         wait_ack(10, got, cyc);
         e = exp_q.pop_front();
         total++;
         if (got !== e || cyc !== 2) begin
            bad++;
            $display("FAIL fair_sb[%0d]: ack=%b rdata=%h cyc=%0d want ack=%b rdata=%h cyc=2",
                     i, got.ack, got.rdata, cyc, e.ack, e.rdata);
         end
         for (int c = 0; c < int'(NCH); c++) if (got.ack[c]) cnt[c]++;
      end
      next_edge();
      m_sel = '0;
      for (int c = 0; c < int'(NCH); c++) begin
         total++;
         if (cnt[c] !== 4) begin
            bad++;
            $display("FAIL fair_count[%0d]: acks=%0d want 4", c, cnt[c]);
         end
      end
   endtask

   task automatic test_timeout();
      exp_t got, e;
      int   cyc;
      s_waits = 0;
      s_hang  = 1'b1;
      set_req(1, 1'b0, 32'h500, 32'h0, 4'hF);
`ifdef MEM_ARB_TIMEOUT_EN
      push_exp(1, 32'h0, 1'b1);
      wait_ack(30, got, cyc);
      e = exp_q.pop_front();
      total++;
      if (got !== e || cyc !== 9) begin
         bad++;
         $display("FAIL tmo_sb: ack=%b rdata=%h err=%b cyc=%0d want ack=%b rdata=%h err=%b cyc=9",
                  got.ack, got.rdata, got.err, cyc, e.ack, e.rdata, e.err);
      end
      next_edge();
      m_sel[1] = 1'b0;
      s_hang   = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL tmo_idle: busy=%b want 0", busy);
      end
`else
      begin
         int odd = 0;
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i >= 2 && (busy !== 1'b1 || m_ack !== '0 || m_err !== '0)) odd++;
         end
         total++;
         if (odd !== 0) begin
            bad++;
            $display("FAIL notmo_wait: bad_cycles=%0d want 0", odd);
         end
      end
      next_edge();
      s_hang = 1'b0;
      push_exp(1, 32'hC0DE0500, 1'b0);
      wait_ack(5, got, cyc);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL notmo_late_ack: ack=%b rdata=%h err=%b want ack=%b rdata=%h err=%b",
                  got.ack, got.rdata, got.err, e.ack, e.rdata, e.err);
      end
      next_edge();
      m_sel[1] = 1'b0;
`endif
   endtask

   initial begin
      rst     = 1'b1;
      m_sel   = '0;
      m_we    = '0;
      m_addr  = '0;
      m_wdata = '0;
      m_wmask = '0;
      test_reset();
      test_single_read();
      test_simultaneous();
      test_masked_write();
      test_reset_mid();
      test_fairness();
      test_timeout();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: entries=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
